// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, ALU-select and phase constants for the multi-cycle CPU
package cpu_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
   localparam logic [1:0] ALU_AND  = 2'b11;

   localparam logic [3:0] T0 = 4'b0001;
   localparam logic [3:0] T1 = 4'b0010;
   localparam logic [3:0] T2 = 4'b0100;
   localparam logic [3:0] T3 = 4'b1000;

   function automatic logic is_phase(input logic [3:0] v);
      return (v == T0) || (v == T1) || (v == T2) || (v == T3);
   endfunction

endpackage

// File: rtl/phase_ctrl_dec.sv
// rtl/phase_ctrl_dec.sv - combinational opcode decoder for the phase sequencer
module phase_ctrl_dec
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_mem_rd_op,
   output logic       is_sta,
   output logic       is_jmp,
   output logic       is_jz,
   output logic       is_hlt,
   output logic [1:0] alu_op
);

   // Opcodes 8-E fall through to the all-zero default and behave as NOP.
   always_comb begin
      is_mem_rd_op = 1'b0;
      is_sta       = 1'b0;
      is_jmp       = 1'b0;
      is_jz        = 1'b0;
      is_hlt       = 1'b0;
      alu_op       = ALU_PASS;
      case (opcode)
         OP_LDA: begin is_mem_rd_op = 1'b1; alu_op = ALU_PASS; end
         OP_ADD: begin is_mem_rd_op = 1'b1; alu_op = ALU_ADD;  end
         OP_SUB: begin is_mem_rd_op = 1'b1; alu_op = ALU_SUB;  end
         OP_AND: begin is_mem_rd_op = 1'b1; alu_op = ALU_AND;  end
         OP_STA: is_sta = 1'b1;
         OP_JMP: is_jmp = 1'b1;
         OP_JZ:  is_jz  = 1'b1;
         OP_HLT: is_hlt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/phase_ctrl.sv
// rtl/phase_ctrl.sv - phase-driven control sequencer owning PC and IR
module phase_ctrl
   import cpu_pkg::*;
#(
   parameter int DW     = 8,
   parameter int PC_RST = 0
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    t,
   input  logic [DW-1:0] instr_in,
   input  logic          acc_zero,
   output logic [DW-5:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [1:0]    alu_op,
   output logic          acc_ld,
   output logic [DW-5:0] pc,
   output logic [DW-1:0] ir,
   output logic          halted,
   output logic          phase_err
);

   localparam int AW = DW - 4;

   logic          legal;
   logic [3:0]    ph;
   logic          bad_phase;
   logic [AW-1:0] operand;
   logic          is_mem_rd_op, is_sta, is_jmp, is_jz, is_hlt;
   logic [1:0]    dec_alu;

   // Illegal vectors and the halted state both collapse to the idle phase.
   assign legal     = is_phase(t);
   assign ph        = (legal && !halted) ? t : 4'b0000;
   assign bad_phase = (t != 4'b0000) && !legal && !halted;
   assign operand   = ir[AW-1:0];

   phase_ctrl_dec u_dec (
      .opcode       (ir[DW-1:DW-4]),
      .is_mem_rd_op (is_mem_rd_op),
      .is_sta       (is_sta),
      .is_jmp       (is_jmp),
      .is_jz        (is_jz),
      .is_hlt       (is_hlt),
      .alu_op       (dec_alu)
   );

   always_comb begin
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = pc;
      alu_op   = ALU_PASS;
      acc_ld   = 1'b0;
      case (ph)
         T0, T1: mem_rd = 1'b1;
         T2: begin
            if (is_mem_rd_op) begin
               mem_rd   = 1'b1;
               mem_addr = operand;
            end else if (is_sta) begin
               mem_wr   = 1'b1;
               mem_addr = operand;
            end
         end
         T3: begin
            if (is_mem_rd_op) begin
               acc_ld = 1'b1;
               alu_op = dec_alu;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= AW'(PC_RST);
         ir        <= '0;
         halted    <= 1'b0;
         phase_err <= 1'b0;
      end else begin
         if (bad_phase)
            phase_err <= 1'b1;
         case (ph)
            T1: begin
               ir <= instr_in;
               pc <= pc + 1'b1;
            end
            T2: begin
               if (is_jmp || (is_jz && acc_zero))
                  pc <= operand;
            end
            T3: begin
               if (is_hlt)
                  halted <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/phase_ctrl.md
Name: phase_ctrl

Overview:
- Phase-driven control sequencer for the multi-cycle CPU.
- Sits directly downstream of the 4-beat phase generator and consumes its one-hot phase vector t (T0=0001, T1=0010, T2=0100, T3=1000; 0000 while the generator is in reset).
- Owns the PC and IR, decodes the instruction, and issues per-phase memory, ALU and accumulator strobes to the datapath.

Parameters:
- DW, 8, instruction/data width; opcode = instr[DW-1:DW-4], operand address = instr[DW-5:0], AW = DW-4.
- PC_RST, 0, PC value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- t  in  4  one-hot phase vector from the phase generator.
- instr_in  in  DW  memory read data, sampled as instruction at T1.
- acc_zero  in  1  accumulator==0 flag from datapath, sampled at T2.
- mem_addr  out  AW  memory address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- alu_op  out  2  00 pass, 01 add, 10 sub, 11 and.
- acc_ld  out  1  accumulator load enable.
- pc  out  AW  current program counter (registered).
- ir  out  DW  current instruction register (registered).
- halted  out  1  processor halted (registered, sticky).
- phase_err  out  1  illegal phase vector seen (registered, sticky).

Behaviour:
- Reset (rst=0, async): pc=PC_RST, ir=0 (NOP), halted=0, phase_err=0. All strobes are 0 because the strobes decode from t and ir.
- Opcodes (4-bit):
  - 0 NOP
  - 1 LDA: acc<=mem[a]
  - 2 STA: mem[a]<=acc
  - 3 ADD
  - 4 SUB
  - 5 AND
  - 6 JMP
  - 7 JZ
  - F HLT
  - 8-E: undefined, executed as NOP.
- Strobes are combinational from t, ir and halted (same-cycle). pc, ir, halted and phase_err are registered and update on posedge clk.
- T0 (fetch): mem_rd=1, mem_addr=pc.
- T1 (latch): mem_rd=1, mem_addr=pc; at the clock edge ir<=instr_in and pc<=pc+1. pc wraps 2^AW-1 -> 0.
- T2 (execute):
  - LDA/ADD/SUB/AND: mem_rd=1, mem_addr=ir operand.
  - STA: mem_wr=1, mem_addr=ir operand, alu_op=00.
  - JMP: pc<=operand at the edge.
  - JZ: pc<=operand at the edge only if acc_zero=1.
  - Others: no strobes.
- T3 (writeback):
  - LDA: acc_ld=1, alu_op=00.
  - ADD: acc_ld=1, alu_op=01.
  - SUB: acc_ld=1, alu_op=10.
  - AND: acc_ld=1, alu_op=11.
  - HLT: halted<=1 at the edge.
- mem_addr defaults to pc whenever no phase selects the operand.
- mem_rd and mem_wr are never both 1.
- While halted=1: all strobes are 0, pc and ir are frozen, t is ignored. Only reset clears halted.
- t=0000: idle; no strobes, no register updates.
- t not one-hot and not 0000: treated as 0000, and phase_err<=1 (sticky until reset).
- A JMP target that equals pc+1 is legal; the jump result overrides the T1 increment because they occur in different phases.
- Reset asserted mid-instruction: all registers return to reset values immediately. Execution restarts with a fetch from PC_RST at the next T0.
- One instruction every 4 clocks. Latency from fetch to accumulator update is 4 cycles (T0..T3).

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT)
  - ALU-select codes
  - phase one-hot constants T0..T3.
- One sub-module, phase_ctrl_dec: purely combinational opcode decoder mapping ir opcode -> {is_mem_rd_op, is_sta, is_jmp, is_jz, is_hlt, alu_op}.
- The sequencing registers stay in phase_ctrl.

Test Plan:
- Reset then phases T0..T3 with instr_in=8'h13 (LDA 3) -> T0/T1 mem_rd=1, mem_addr=0. After T1: ir=13, pc=1. T2: mem_rd=1, mem_addr=3. T3: acc_ld=1, alu_op=00.
- ir=8'h25 (STA 5) -> T2: mem_wr=1, mem_rd=0, mem_addr=5. No acc_ld at T3.
- ir=8'h7A (JZ A), acc_zero=0 then a repeat with acc_zero=1 -> pc stays at fetch+1 in the first case; pc=A after T2 in the second.
- pc=F fetching 8'h00 -> after T1, pc=0 (wrap).
- ir=8'hF0 (HLT) -> halted=1 after T3. The following 8 phases produce no strobes and pc is unchanged.
- Apply t=0110 -> phase_err=1 with no strobes. Then rst=0 asynchronously mid-T2 -> pc=0, ir=0, halted=0, phase_err=0 before the next clock edge.
